// File: rtl/setup_window_monitor.sv
`default_nettype none
// ============================================================================
// Module      : setup_window_monitor
// Description : Run-time setup-window checker. It measures the age of the
//               last data transition at each reference rising edge and flags
//               ages below a programmable limit.
//               Optional macro SETUP_MON_COND_EVENT_EN gates checks with cond.
// Revision    : 1.0 - initial release
// ============================================================================
module setup_window_monitor #(
    parameter int CNT_W  = 8,
    parameter int VCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data,
    input  logic              ref_in,
    input  logic              cond,
    input  logic [CNT_W-1:0]  limit,
    input  logic              clear_cnt,
    output logic              armed,
    output logic              viol,
    output logic              notifier,
    output logic [VCNT_W-1:0] viol_count,
    output logic [CNT_W-1:0]  last_slack
);

    typedef enum logic [1:0] {
        PRIME = 2'd0,
        IDLE  = 2'd1,
        ARMED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  C_AGE_MAX = '1;
    localparam logic [VCNT_W-1:0] C_CNT_MAX = '1;

    state_t              state_q, state_d;
    logic                data_q, data_d;
    logic                ref_q, ref_d;
    logic [CNT_W-1:0]    age_q, age_d;
    logic                armed_q, armed_d;
    logic                viol_q, viol_d;
    logic                notifier_q, notifier_d;
    logic [VCNT_W-1:0]   viol_count_q, viol_count_d;
    logic [CNT_W-1:0]    last_slack_q, last_slack_d;

    logic                data_edge;
    logic                ref_rise;
    logic                check_evt;
    logic                viol_hit;
    logic [CNT_W-1:0]    eff_age;
    logic [VCNT_W-1:0]   count_base;

`ifdef SETUP_MON_COND_EVENT_EN
    logic                cond_ok;
    assign cond_ok = cond;
`else
    logic                cond_ok;
    logic                unused_cond;
    assign cond_ok     = 1'b1;
    assign unused_cond = cond;
`endif

    always_comb begin
        state_d    = state_q;
        data_d     = data;
        ref_d      = ref_in;
        age_d      = age_q;
        data_edge  = (state_q != PRIME) && (data != data_q);
        ref_rise   = (state_q != PRIME) && ref_in && !ref_q;

        case (state_q)
            PRIME: begin
                state_d = IDLE;
                age_d   = '0;
            end
            IDLE: begin
                if (data_edge) begin
                    state_d = ARMED;
                    age_d   = '0;
                end
            end
            ARMED: begin
                if (data_edge) begin
                    age_d = '0;
                end else if (age_q != C_AGE_MAX) begin
                    age_d = age_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = PRIME;
                age_d   = '0;
            end
        endcase

        // A data edge coincident with the reference edge counts as zero setup.
        eff_age   = data_edge ? '0 : age_q;
        check_evt = ref_rise && cond_ok &&
                    ((state_q == ARMED) || ((state_q == IDLE) && data_edge));
        viol_hit  = check_evt && (limit != '0) && (eff_age < limit);

        armed_d      = (state_d == ARMED);
        viol_d       = viol_hit;
        notifier_d   = notifier_q ^ viol_hit;

        // Clear takes effect first so a same-cycle violation lands on a zeroed count.
        count_base   = clear_cnt ? '0 : viol_count_q;
        viol_count_d = count_base;
        last_slack_d = clear_cnt ? '0 : last_slack_q;
        if (viol_hit) begin
            last_slack_d = limit - eff_age;
            if (count_base != C_CNT_MAX) begin
                viol_count_d = count_base + VCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= PRIME;
            data_q       <= 1'b0;
            ref_q        <= 1'b0;
            age_q        <= '0;
            armed_q      <= 1'b0;
            viol_q       <= 1'b0;
            notifier_q   <= 1'b0;
            viol_count_q <= '0;
            last_slack_q <= '0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            ref_q        <= ref_d;
            age_q        <= age_d;
            armed_q      <= armed_d;
            viol_q       <= viol_d;
            notifier_q   <= notifier_d;
            viol_count_q <= viol_count_d;
            last_slack_q <= last_slack_d;
        end
    end

    assign armed      = armed_q;
    assign viol       = viol_q;
    assign notifier   = notifier_q;
    assign viol_count = viol_count_q;
    assign last_slack = last_slack_q;

endmodule
`default_nettype wire

// File: tb/tb_setup_window_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_setup_window_monitor
// Description : Scoreboard bench for setup_window_monitor (VCNT_W=2 instance).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_setup_window_monitor;

    localparam int CNT_W  = 8;
    localparam int VCNT_W = 2;

    logic              clk;
    logic              rst;
    logic              data;
    logic              ref_in;
    logic              cond;
    logic [CNT_W-1:0]  limit;
    logic              clear_cnt;
    logic              armed;
    logic              viol;
    logic              notifier;
    logic [VCNT_W-1:0] viol_count;
    logic [CNT_W-1:0]  last_slack;

    typedef struct {
        int slack;
        int cnt;
        int notif;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   m_cnt = 0;
    int   m_notif = 0;

    setup_window_monitor #(.CNT_W(CNT_W), .VCNT_W(VCNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .ref_in     (ref_in),
        .cond       (cond),
        .limit      (limit),
        .clear_cnt  (clear_cnt),
        .armed      (armed),
        .viol       (viol),
        .notifier   (notifier),
        .viol_count (viol_count),
        .last_slack (last_slack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every viol pulse must match the oldest expected violation.
    always @(negedge clk) begin
        if (!rst && viol) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_viol", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("last_slack", int'(last_slack), e.slack);
                chk("viol_count", int'(viol_count), e.cnt);
                chk("notifier", int'(notifier), e.notif);
            end
        end
    end

    // Data toggles, ref_in rises 'gap' cycles later; age at the rise is gap-1
    // (age reloads to 0 on the edge cycle and counts from the next cycle).
    task automatic ev(input int gap, input int lim, input bit cnd, input bit clr);
        int   eff;
        int   base;
        bit   hit;
        exp_t e;
        data  = ~data;
        limit = lim[CNT_W-1:0];
        cond  = cnd;
        if (gap > 0) repeat (gap) step();
        ref_in    = 1'b1;
        clear_cnt = clr;
        eff = (gap == 0) ? 0 : gap - 1;
        hit = (lim != 0) && (eff < lim);
`ifdef SETUP_MON_COND_EVENT_EN
        hit = hit && cnd;
`endif
        base = clr ? 0 : m_cnt;
        if (hit) begin
            m_cnt   = (base == 3) ? 3 : base + 1;
            m_notif = m_notif ^ 1;
            e.slack = lim - eff;
            e.cnt   = m_cnt;
            e.notif = m_notif;
            exp_q.push_back(e);
        end else begin
            m_cnt = base;
        end
        step();
        ref_in    = 1'b0;
        clear_cnt = 1'b0;
        repeat (3) step();
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; data = 1'b0; ref_in = 1'b0; cond = 1'b1;
        limit = '0; clear_cnt = 1'b0;
        repeat (3) step();
        chk("rst_armed", int'(armed), 0);
        chk("rst_viol", int'(viol), 0);
        chk("rst_notifier", int'(notifier), 0);
        chk("rst_count", int'(viol_count), 0);
        chk("rst_slack", int'(last_slack), 0);
        rst = 1'b0;
        repeat (2) step();

        // Reference pulses without any data transition: nothing checked.
        limit = 8'd4;
        repeat (5) begin
            ref_in = 1'b1; step();
            ref_in = 1'b0; step();
        end
        chk("idle_armed", int'(armed), 0);
        chk("idle_count", int'(viol_count), 0);

        ev(3, 4, 1'b1, 1'b0);              // age 2 -> slack 2
        chk("armed_after_edge", int'(armed), 1);
        ev(7, 4, 1'b1, 1'b0);              // age 6 -> clean
        ev(2, 0, 1'b1, 1'b0);              // limit 0 -> disabled
        ev(0, 1, 1'b1, 1'b0);              // simultaneous -> slack 1
        ev(2, 4, 1'b0, 1'b0);              // cond low
        ev(2, 4, 1'b1, 1'b0);              // cond high
        ev(1, 4, 1'b1, 1'b0);              // count saturation
        ev(1, 4, 1'b1, 1'b0);
        ev(1, 4, 1'b1, 1'b1);              // clear with violation -> 1
        ev(7, 4, 1'b1, 1'b1);              // clear alone
        chk("clear_count", int'(viol_count), 0);
        chk("clear_slack", int'(last_slack), 0);

        // Asynchronous reset while a viol pulse is showing.
        data = ~data; limit = 8'd4; cond = 1'b1;
        step();
        ref_in = 1'b1;
        step();
        chk("viol_before_rst", int'(viol), 1);
        ref_in = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_armed", int'(armed), 0);
        chk("arst_viol", int'(viol), 0);
        chk("arst_notifier", int'(notifier), 0);
        chk("arst_count", int'(viol_count), 0);
        chk("arst_slack", int'(last_slack), 0);
        m_cnt = 0; m_notif = 0;
        step();
        rst = 1'b0;
        repeat (2) step();
        chk("post_rst_armed", int'(armed), 0);
        ev(3, 4, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/setup_window_monitor.md
Name: setup_window_monitor

Overview:
- Synthesizable run-time monitor for the setup relation between a data signal and a reference edge.
- It mirrors a conditioned setup timing check in silicon. The `data` and `ref_in` signals are sampled on a fast sampling clock.
- It measures how many sample cycles separate the last data transition from each reference rising edge, and flags a violation when that age is below a programmable limit.
- It sits beside capture logic in debug/characterisation builds and feeds a status/counter interface.

Parameters:
- CNT_W, 8: width of the age counter, `limit` and `last_slack`.
- VCNT_W, 16: width of the saturating violation counter.

Ports:
- clk  input  1  sampling clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- data  input  1  monitored data signal, already synchronous to clk.
- ref_in  input  1  monitored reference signal; its rising edge is the check event.
- cond  input  1  check-enable condition, equivalent to `&&&` on the reference event.
- limit  input  CNT_W  required setup in clk cycles; 0 disables checking.
- clear_cnt  input  1  synchronous clear of `viol_count` and `last_slack`.
- armed  output  1  high once a data transition has been seen since reset.
- viol  output  1  one-cycle violation pulse.
- notifier  output  1  toggles on every violation.
- viol_count  output  VCNT_W  saturating violation count.
- last_slack  output  CNT_W  shortfall (`limit` minus age) of the most recent violation.

Behaviour:
- Reset (async, rst=1):
  - State = PRIME.
  - `data_q`, `ref_q`, `age` = 0.
  - `armed`, `viol`, `notifier` = 0.
  - `viol_count`, `last_slack` = 0.
- State machine:
  - PRIME: for 1 cycle, load `data_q` <= `data` and `ref_q` <= `ref_in`. No edges are detected in this cycle. Go to IDLE.
  - IDLE: `data_edge` = (`data` != `data_q`). Reference edges are ignored. On `data_edge`, go to ARMED with `age` <= 0.
  - ARMED: stays ARMED until reset. `age` increments by 1 per cycle, saturating at 2^CNT_W-1. `data_edge` reloads `age` to 0.
  - `armed` = 1 exactly while in ARMED.
- Edge detection (every non-PRIME cycle): `data_q` <= `data`, `ref_q` <= `ref_in`, and `ref_rise` = `ref_in` & ~`ref_q`.
- Check event: `ref_rise` while in ARMED, gated per the Optional Feature. A `ref_rise` in the same cycle as the IDLE->ARMED transition is also checked, with eff_age = 0.
- eff_age:
  - Equals 0 if `data_edge` occurs in the same cycle (simultaneous events count as zero setup).
  - Otherwise equals the current registered `age`.
- Violation is declared iff `limit` != 0 and eff_age < `limit` (unsigned compare).
- Outputs registered; the update is visible the cycle after the check event:
  - `viol` = 1 for exactly one cycle.
  - `notifier` inverts.
  - `last_slack` <= `limit` - eff_age.
  - `viol_count` += 1, holding at 2^VCNT_W-1.
- `clear_cnt`:
  - Next cycle, `viol_count` = 0 and `last_slack` = 0.
  - If a violation occurs in the same cycle, `viol_count` = 1 and `last_slack` = the new slack; clear applies first, then the increment.
  - Does not affect state, `age` or `notifier`.
- `limit` is sampled in the check cycle only; changing it between events is legal.
- Back-to-back `ref_rise` is impossible by construction (it needs a low cycle between rises). Each rise is checked independently.
- Asserting rst mid-operation returns to PRIME immediately. Any pending `viol` pulse is dropped.

Optional Feature:
- Macro: SETUP_MON_COND_EVENT_EN.
- Defined: the check event = `ref_rise` & `cond` (conditioned event, as with `&&&`). With `cond`=0 at the edge, no check is made and no outputs change; `age` still tracks normally.
- Not defined: `cond` is ignored (port kept, unused) and every `ref_rise` in ARMED is checked.

Test Plan:
- Reset release, `data` constant 0, `ref_in` pulsed 5 times -> `armed`=0, `viol` never 1, `viol_count`=0.
- `limit`=4, `data` toggles, `ref_in` rises 2 cycles later -> `viol` pulse 1 cycle after the rise, `last_slack`=2, `viol_count`=1, `notifier`=1.
- `limit`=4, `data` toggles, `ref_in` rises 6 cycles later -> no `viol`, `viol_count` unchanged; repeat with `limit`=0 and a 1-cycle gap -> no `viol`.
- Simultaneous events: `data` toggle and `ref_in` rise in the same cycle with `limit`=1 -> `viol`, `last_slack`=1.
- With SETUP_MON_COND_EVENT_EN, `limit`=4, 1-cycle setup, `cond`=0 -> no `viol`; same stimulus with `cond`=1 -> `viol`. Without the macro, both cases -> `viol`.
- VCNT_W=2: force 5 violations -> `viol_count` holds at 3. Assert `clear_cnt` together with the 6th violation -> `viol_count`=1. Assert rst mid-sequence -> all outputs return to 0 asynchronously.
